// File: rtl/dfm_bus_arbiter.sv
// Two-port arbiter for the single-port data memory (DFM): CPU port 0, secondary master port 1.
// Define DFM_ARB_ROUND_ROBIN_EN for round-robin IDLE arbitration instead of port-0 priority with a starvation override.
module dfm_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 8,
  parameter int LOCK_MAX   = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  p0_req,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic                  p0_wr_en,
  input  logic [DATA_WIDTH-1:0] p0_wr_data,
  input  logic                  p0_lock,
  output logic                  p0_gnt,
  output logic                  p0_rd_valid,
  output logic [DATA_WIDTH-1:0] p0_rd_data,
  input  logic                  p1_req,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic                  p1_wr_en,
  input  logic [DATA_WIDTH-1:0] p1_wr_data,
  input  logic                  p1_lock,
  output logic                  p1_gnt,
  output logic                  p1_rd_valid,
  output logic [DATA_WIDTH-1:0] p1_rd_data,
  output logic [ADDR_WIDTH-1:0] dfm_req_addr,
  output logic                  dfm_wr_en,
  output logic [DATA_WIDTH-1:0] dfm_wr_data,
  input  logic [DATA_WIDTH-1:0] dfm_rd_data,
  output logic [1:0]            dbg_state
);

  // Handshake: a beat completes in the cycle where pX_req and pX_gnt are both high;
  // a requester holds its request fields stable until it sees gnt. Reads return
  // on pX_rd_valid exactly one cycle after the completing beat.

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  localparam logic [7:0] LOCK_MAX8 = 8'(LOCK_MAX);

  state_t                state_q, state_d;
  logic [7:0]            lock_cnt_q, lock_cnt_d;
  logic [7:0]            lock_inc;
  logic                  yield_q, yield_d;
  logic                  yield_port_q, yield_port_d;
  logic                  g0, g1, any_gnt;
  logic                  own_port, own_req, own_lock;
  logic                  rd_pend_q, rd_owner_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  sel_wr;

`ifdef DFM_ARB_ROUND_ROBIN_EN
  logic last_gnt_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst)      last_gnt_q <= 1'b1;
    else if (any_gnt) last_gnt_q <= g1;
  end
`else
  localparam logic [7:0] MAX_WAIT8 = 8'(MAX_WAIT);
  logic [7:0] wait_cnt_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || !p1_req || g1) wait_cnt_q <= '0;
    else if (wait_cnt_q != MAX_WAIT8) wait_cnt_q <= wait_cnt_q + 8'd1;
  end
`endif

  assign own_port = (state_q == OWN1);
  assign own_req  = own_port ? p1_req  : p0_req;
  assign own_lock = own_port ? p1_lock : p0_lock;
  assign lock_inc = lock_cnt_q + 8'd1;

  // Grant decision; yield_q gives the other port one cycle of priority after a lock cap
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (state_q == OWN0)      g0 = p0_req;
    else if (state_q == OWN1) g1 = p1_req;
    else if (yield_q && yield_port_q && p1_req)  g1 = 1'b1;
    else if (yield_q && !yield_port_q && p0_req) g0 = 1'b1;
`ifdef DFM_ARB_ROUND_ROBIN_EN
    else if (p0_req && p1_req) begin
      g0 = last_gnt_q;
      g1 = !last_gnt_q;
    end
    else begin
      g0 = p0_req;
      g1 = p1_req;
    end
`else
    else if (p1_req && (wait_cnt_q == MAX_WAIT8)) g1 = 1'b1;
    else if (p0_req) g0 = 1'b1;
    else             g1 = p1_req;
`endif
    if (sys_rst) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    yield_d      = 1'b0;
    yield_port_d = yield_port_q;
    if (state_q == IDLE) begin
      lock_cnt_d = '0;
      if (g0 && p0_lock)      state_d = OWN0;
      else if (g1 && p1_lock) state_d = OWN1;
    end else if (!own_req) begin
      state_d    = IDLE;
      lock_cnt_d = '0;
    end else if (lock_inc == LOCK_MAX8) begin
      state_d      = IDLE;
      lock_cnt_d   = '0;
      yield_d      = 1'b1;
      yield_port_d = !own_port;
    end else begin
      lock_cnt_d = lock_inc;
      if (!own_lock) state_d = IDLE;
    end
  end

  assign any_gnt      = g0 | g1;
  assign sel_wr       = g1 ? p1_wr_en : p0_wr_en;
  assign dfm_wr_en    = any_gnt & sel_wr;
  assign dfm_req_addr = g1 ? p1_addr : (g0 ? p0_addr : addr_q);
  assign dfm_wr_data  = g1 ? p1_wr_data : (g0 ? p0_wr_data : wdata_q);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      lock_cnt_q   <= '0;
      yield_q      <= 1'b0;
      yield_port_q <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      yield_q      <= yield_d;
      yield_port_q <= yield_port_d;
      rd_pend_q    <= any_gnt & !sel_wr;
      if (any_gnt & !sel_wr) rd_owner_q <= g1;
      if (any_gnt) begin
        addr_q  <= dfm_req_addr;
        wdata_q <= dfm_wr_data;
      end
    end
  end

  assign p0_gnt      = g0;
  assign p1_gnt      = g1;
  assign p0_rd_valid = rd_pend_q & !rd_owner_q & !sys_rst;
  assign p1_rd_valid = rd_pend_q & rd_owner_q & !sys_rst;
  assign p0_rd_data  = p0_rd_valid ? dfm_rd_data : '0;
  assign p1_rd_data  = p1_rd_valid ? dfm_rd_data : '0;
  assign dbg_state   = state_q;

endmodule
